// File: rtl/piso_unit.sv
// -----------------------------------------------------------------------------
// piso_unit
// Free-running parallel-in serial-out framer for the UART transmit path.
// Every WIDTH clocks the parallel word is sampled once (load edge) and then
// emitted one bit per clock on q, with no idle gap between frames.
//
// Ports:
//   clk    in   1      system clock, rising-edge active
//   reset  in   1      synchronous reset, active-high
//   data   in   WIDTH  parallel word, sampled only on load edges
//   q      out  1      serial output bit, registered
//
// Parameters:
//   WIDTH  word width and frame length in clocks (WIDTH >= 2)
//
// Build option:
//   PISO_LSB_FIRST_EN  defined   -> LSB-first emission (standard UART order)
//                      undefined -> MSB-first emission
// -----------------------------------------------------------------------------
module piso_unit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data,
    output logic             q
);

    localparam int unsigned CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int unsigned LAST_BIT = WIDTH - 1;

    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             q_q, q_d;
    logic             load_c;

    // cnt counts bits still to emit after the current q; zero means load.
    assign load_c = (cnt_q == '0);

    // Next-state logic: load a fresh word or shift the current one out.
    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        q_d   = q_q;
        if (load_c) begin
`ifdef PISO_LSB_FIRST_EN
            q_d  = data[0];
            sr_d = {1'b0, data[WIDTH-1:1]};
`else
            q_d  = data[WIDTH-1];
            sr_d = {data[WIDTH-2:0], 1'b0};
`endif
            cnt_d = CNT_W'(LAST_BIT);
        end else begin
`ifdef PISO_LSB_FIRST_EN
            q_d  = sr_q[0];
            sr_d = {1'b0, sr_q[WIDTH-1:1]};
`else
            q_d  = sr_q[WIDTH-1];
            sr_d = {sr_q[WIDTH-2:0], 1'b0};
`endif
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // State registers; reset aborts any frame and forces the next edge to load.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q  <= '0;
            cnt_q <= '0;
            q_q   <= 1'b0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
            q_q   <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: tb/tb_piso_unit.sv
// -----------------------------------------------------------------------------
// tb_piso_unit
// Self-checking bench for piso_unit: an 8-bit and a 4-bit instance run side by
// side and are compared each edge against a frame-level reference model
// (latched word + bit index within the frame).
// -----------------------------------------------------------------------------
module tb_piso_unit;

    localparam int unsigned W8 = 8;
    localparam int unsigned W4 = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [W8-1:0] data8 = '0;
    logic [W4-1:0] data4 = '0;
    logic          q8, q4;

    int checks   = 0;
    int failures = 0;

    // Reference model state: next bit index of the frame and latched word.
    int            pos8 = 0;
    int            pos4 = 0;
    logic [31:0]   word8 = '0;
    logic [31:0]   word4 = '0;
    logic          exp8 = 1'b0;
    logic          exp4 = 1'b0;

    piso_unit #(.WIDTH(W8)) u_dut8 (
        .clk   (clk),
        .reset (reset),
        .data  (data8),
        .q     (q8)
    );

    piso_unit #(.WIDTH(W4)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .data  (data4),
        .q     (q4)
    );

    always #5 clk = ~clk;

    // Bit k of a frame (k = 0 is the first bit sent).
    function automatic logic frame_bit(input logic [31:0] w, input int width, input int k);
`ifdef PISO_LSB_FIRST_EN
        frame_bit = w[k];
`else
        frame_bit = w[width-1-k];
`endif
    endfunction

    // Drive inputs, take one clock edge, sample 1 time unit later, advance model.
    task automatic edge_step(input logic r, input logic [W8-1:0] d8, input logic [W4-1:0] d4);
        reset = r;
        data8 = d8;
        data4 = d4;
        @(posedge clk);
        #1;
        if (r) begin
            exp8 = 1'b0;
            exp4 = 1'b0;
            pos8 = 0;
            pos4 = 0;
        end else begin
            if (pos8 == 0) word8 = 32'(d8);
            exp8 = frame_bit(word8, W8, pos8);
            pos8 = (pos8 + 1) % W8;
            if (pos4 == 0) word4 = 32'(d4);
            exp4 = frame_bit(word4, W4, pos4);
            pos4 = (pos4 + 1) % W4;
        end
    endtask

    // Run edges with held data until the 8-bit model is at a frame boundary.
    task automatic align8(input logic [W8-1:0] d8);
        while (pos8 != 0) edge_step(1'b0, d8, W4'($urandom));
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            edge_step(1'b1, 8'hFF, 4'hF);
            checks++;
            if (q8 !== 1'b0) begin
                failures++;
                $display("FAIL reset_q8 edge %0d: got %b want 0", i, q8);
            end
            checks++;
            if (q4 !== 1'b0) begin
                failures++;
                $display("FAIL reset_q4 edge %0d: got %b want 0", i, q4);
            end
        end
    endtask

    task automatic test_frame_a();
        logic [W8-1:0] vec;
        vec = 8'h99;
        // 8 bits of the frame plus the 9th edge, which starts a new load.
        for (int k = 0; k < 9; k++) begin
            edge_step(1'b0, 8'h99, 4'h9);
            checks++;
            if (q8 !== exp8) begin
                failures++;
                $display("FAIL frame_a bit %0d: got %b want %b", k, q8, exp8);
            end
            checks++;
            if (q8 !== vec[7 - (k % 8)]) begin
                failures++;
                $display("FAIL frame_a_const bit %0d: got %b want %b", k, q8, vec[7 - (k % 8)]);
            end
        end
    endtask

    task automatic test_frame_b();
        logic held;
        align8(8'h61);
        for (int k = 0; k < W8; k++) begin
            // data drops to 0x00 from the third bit onward; frame must be unaffected
            edge_step(1'b0, (k < 2) ? 8'h61 : 8'h00, W4'($urandom));
            checks++;
            if (q8 !== exp8) begin
                failures++;
                $display("FAIL frame_b bit %0d: got %b want %b", k, q8, exp8);
            end
        end
        // q must not follow data between edges
        held  = q8;
        data8 = ~data8;
        #2;
        checks++;
        if (q8 !== held) begin
            failures++;
            $display("FAIL no_comb_path: got %b want %b", q8, held);
        end
    endtask

    task automatic test_back_to_back();
        align8(8'hA5);
        for (int k = 0; k < 3 * W8; k++) begin
            edge_step(1'b0, (k < 16) ? 8'hA5 : 8'h3C, W4'($urandom));
            checks++;
            if (q8 !== exp8) begin
                failures++;
                $display("FAIL back_to_back bit %0d: got %b want %b", k, q8, exp8);
            end
            checks++;
            if (q4 !== exp4) begin
                failures++;
                $display("FAIL back_to_back_w4 bit %0d: got %b want %b", k, q4, exp4);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        align8(8'hFF);
        for (int k = 0; k < 3; k++) edge_step(1'b0, 8'hFF, 4'hF);
        edge_step(1'b1, 8'hFF, 4'hF);
        checks++;
        if (q8 !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: got %b want 0", q8);
        end
        for (int k = 0; k < W8; k++) begin
            edge_step(1'b0, 8'h81, 4'h9);
            checks++;
            if (q8 !== exp8) begin
                failures++;
                $display("FAIL after_reset bit %0d: got %b want %b", k, q8, exp8);
            end
        end
    endtask

    task automatic test_width4();
        edge_step(1'b1, 8'h00, 4'h0);
        for (int k = 0; k < 3 * W4; k++) begin
            edge_step(1'b0, W8'($urandom), 4'h9);
            checks++;
            if (q4 !== exp4) begin
                failures++;
                $display("FAIL width4 bit %0d: got %b want %b", k, q4, exp4);
            end
        end
    endtask

    task automatic test_random();
        logic r;
        for (int n = 0; n < 400; n++) begin
            r = ($urandom_range(0, 24) == 0);
            edge_step(r, W8'($urandom), W4'($urandom));
            checks++;
            if (q8 !== exp8) begin
                failures++;
                $display("FAIL random_w8 edge %0d: got %b want %b", n, q8, exp8);
            end
            checks++;
            if (q4 !== exp4) begin
                failures++;
                $display("FAIL random_w4 edge %0d: got %b want %b", n, q4, exp4);
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame_a();
        test_frame_b();
        test_back_to_back();
        test_reset_mid_frame();
        test_width4();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/piso_unit.md
Name: piso_unit

Overview:
- Parallel-in serial-out shift register feeding the UART transmit serial path.
- Free-running framer: every WIDTH clock cycles it samples the parallel `data` word once, then emits it one bit per clock on `q`, MSB first by default.
- No load or valid handshake. Upstream must hold `data` stable across each load edge.

Parameters:
- WIDTH, default 8: parallel word width and frame length in clock cycles. Legal range is WIDTH >= 2.

Ports:
- clk    input   1      system clock; all state updates on the rising edge
- reset  input   1      synchronous reset, active-high
- data   input   WIDTH  parallel word; sampled only on load edges
- q      output  1      serial output bit, registered

Behaviour:
- Interface: one clock (`clk`); reset (`reset`) is synchronous and active-high.
- Internal state:
  - shift register `sr[WIDTH-1:0]`
  - down-counter `cnt`, $clog2(WIDTH) bits, holding the number of bits of the current frame still to emit after `q`
  - output register `q`
- Reset: on a rising edge with reset=1, sr<=0, cnt<=0, q<=0. Reset overrides everything else and aborts any frame in progress; no partial bits are emitted after it.
- Load edge (reset=0, cnt==0):
  - q<=data[WIDTH-1]
  - sr<={data[WIDTH-2:0],1'b0}
  - cnt<=WIDTH-1
- Shift edge (reset=0, cnt!=0):
  - q<=sr[WIDTH-1]
  - sr<={sr[WIDTH-2:0],1'b0}
  - cnt<=cnt-1
- Consequences:
  - The first edge after reset release is always a load edge.
  - Frames repeat back-to-back with period WIDTH cycles and no idle gap.
  - Bit k of a frame (k=0 is the MSB) is visible on `q` from load edge + k until the next edge.
  - Latency from data sample to first serial bit is 1 clock: `q` is valid after the load edge.
- Changes on `data` between load edges are ignored.
- Holding reset=1 keeps q=0 indefinitely.
- If reset deasserts in the same cycle that `data` changes, the new `data` is what gets loaded on the next edge.
- No combinational path from any input to `q`.
- Counter wrap: cnt never underflows; the state cnt==0 always selects a load.

Optional Feature:
- Macro PISO_LSB_FIRST_EN.
- Defined:
  - Load edge: q<=data[0], sr<={1'b0,data[WIDTH-1:1]}.
  - Shift edge: q<=sr[0], sr<={1'b0,sr[WIDTH-1:1]}.
  - Result: word emitted LSB first, which is standard UART bit order.
- Undefined: MSB-first as specified above.
- Timing, reset and counter behaviour are identical in both builds.

Test Plan:
- Reset: hold reset=1 for 3 edges with data=0xFF -> q=0 after each edge.
- Frame A: release reset with data=0x99 stable before the first edge -> q over 8 edges = 1,0,0,1,1,0,0,1. On the 9th edge a new load occurs.
- Frame B: data=0x61 at load -> q = 0,1,1,0,0,0,0,1. Toggling data to 0x00 on edge 3 of the frame does not alter the remaining bits.
- Back-to-back frames: data=0xA5 for 16 edges, then 0x3C -> q = 10100101 10100101 00111100 with no gap bits.
- Reset mid-frame: assert reset on the 4th bit of frame 0xFF -> q=0 at the next edge. After release with data=0x81, the next frame is 1,0,0,0,0,0,0,1 starting at the first edge.
- PISO_LSB_FIRST_EN defined, data=0x61 -> q = 1,0,0,0,0,1,1,0. With WIDTH=4 and data=0x9 (MSB-first build) -> q = 1,0,0,1, period 4.
